// File: rtl/fila_ativos_pkg.sv
// rtl/fila_ativos_pkg.sv - shared types and width helpers for the active-node set
// Contents: estado_t (OCIOSO, BUSCA, ENTREGA), clog2(), criterio_width().
package fila_ativos_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // distancia + heuristica (heuristica no wider than distancia) needs one carry bit
  function automatic int criterio_width(input int distancia_width);
    return distancia_width + 1;
  endfunction

endpackage

// File: rtl/slot_ativo.sv
// rtl/slot_ativo.sv - one active-node slot with address compare
// Ports:
//   clk, rst_n           clock, async active-low reset
//   limpar               sync clear of the valid bit
//   invalidar            free the slot (pop delivery)
//   escrever             allocate: load all fields and set valid
//   relaxar              overwrite distancia/anterior/criterio of a valid slot
//   endereco_in ...      write data; endereco_in is also the compare key
//   valido, endereco, distancia, anterior, criterio   stored contents
//   casa                 slot valid and its endereco equals endereco_in
module slot_ativo #(
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CRITERIO_WIDTH  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       limpar,
  input  logic                       invalidar,
  input  logic                       escrever,
  input  logic                       relaxar,
  input  logic [ADDR_WIDTH-1:0]      endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0] distancia_in,
  input  logic [ADDR_WIDTH-1:0]      anterior_in,
  input  logic [CRITERIO_WIDTH-1:0]  criterio_in,
  output logic                       valido,
  output logic [ADDR_WIDTH-1:0]      endereco,
  output logic [DISTANCIA_WIDTH-1:0] distancia,
  output logic [ADDR_WIDTH-1:0]      anterior,
  output logic [CRITERIO_WIDTH-1:0]  criterio,
  output logic                       casa
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valido    <= 1'b0;
      endereco  <= '0;
      distancia <= '0;
      anterior  <= '0;
      criterio  <= '0;
    end else if (limpar || invalidar) begin
      valido <= 1'b0;
    end else if (escrever) begin
      valido    <= 1'b1;
      endereco  <= endereco_in;
      distancia <= distancia_in;
      anterior  <= anterior_in;
      criterio  <= criterio_in;
    end else if (relaxar) begin
      distancia <= distancia_in;
      anterior  <= anterior_in;
      criterio  <= criterio_in;
    end
  end

  assign casa = valido && (endereco == endereco_in);

endmodule

// File: rtl/fila_ativos_min.sv
// rtl/fila_ativos_min.sv - active-node set with insert/relax and pop-minimum
// Ports:
//   clk, rst_n, limpar_in                 clock, async reset, sync clear
//   cmd_valid_in/cmd_ready_out + cmd_*    insert-or-relax command
//   cmd_descartado_out                    pulse: command dropped
//   pop_req_in/pop_ready_out              pop-minimum request
//   pop_valid_out, pop_nulo_out, pop_*    pop result strobe and held data
//   fa_ocupacao_out, fa_vazio_out, fa_cheio_out, fa_overflow_out   status
module fila_ativos_min
  import fila_ativos_pkg::*;
#(
  parameter int NUM_NA          = 8,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int HEUR_WIDTH      = 5,
  parameter int CRITERIO_WIDTH  = criterio_width(DISTANCIA_WIDTH),
  parameter int IDX_WIDTH       = clog2(NUM_NA)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       limpar_in,
  input  logic                       cmd_valid_in,
  output logic                       cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0]      cmd_endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0] cmd_distancia_in,
  input  logic [HEUR_WIDTH-1:0]      cmd_heuristica_in,
  input  logic [ADDR_WIDTH-1:0]      cmd_anterior_in,
  output logic                       cmd_descartado_out,
  input  logic                       pop_req_in,
  output logic                       pop_ready_out,
  output logic                       pop_valid_out,
  output logic                       pop_nulo_out,
  output logic [ADDR_WIDTH-1:0]      pop_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0] pop_distancia_out,
  output logic [ADDR_WIDTH-1:0]      pop_anterior_out,
  output logic [IDX_WIDTH:0]         fa_ocupacao_out,
  output logic                       fa_vazio_out,
  output logic                       fa_cheio_out,
  output logic                       fa_overflow_out
);

  estado_t estado, estado_prox;

  // slot array
  logic [NUM_NA-1:0]          s_valido, s_casa, s_escrever, s_relaxar, s_invalidar;
  logic [ADDR_WIDTH-1:0]      s_endereco  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] s_distancia [NUM_NA];
  logic [ADDR_WIDTH-1:0]      s_anterior  [NUM_NA];
  logic [CRITERIO_WIDTH-1:0]  s_criterio  [NUM_NA];

  logic [CRITERIO_WIDTH-1:0] crit_cmd;
  assign crit_cmd = CRITERIO_WIDTH'(cmd_distancia_in) + CRITERIO_WIDTH'(cmd_heuristica_in);

  for (genvar g = 0; g < NUM_NA; g++) begin : g_slot
    slot_ativo #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .DISTANCIA_WIDTH (DISTANCIA_WIDTH),
      .CRITERIO_WIDTH  (CRITERIO_WIDTH)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .limpar       (limpar_in),
      .invalidar    (s_invalidar[g]),
      .escrever     (s_escrever[g]),
      .relaxar      (s_relaxar[g]),
      .endereco_in  (cmd_endereco_in),
      .distancia_in (cmd_distancia_in),
      .anterior_in  (cmd_anterior_in),
      .criterio_in  (crit_cmd),
      .valido       (s_valido[g]),
      .endereco     (s_endereco[g]),
      .distancia    (s_distancia[g]),
      .anterior     (s_anterior[g]),
      .criterio     (s_criterio[g]),
      .casa         (s_casa[g])
    );
  end

  // accepted handshakes; limpar_in suppresses both
  logic cmd_fire, pop_fire;
  assign cmd_fire = (estado == OCIOSO) && cmd_valid_in && !limpar_in;
  assign pop_fire = (estado == OCIOSO) && pop_req_in && !cmd_valid_in && !limpar_in;

  // occupancy as a popcount of the valid bits
  logic [IDX_WIDTH:0] ocupacao;
  always_comb begin
    ocupacao = '0;
    for (int k = 0; k < NUM_NA; k++) begin
      ocupacao = ocupacao + (IDX_WIDTH+1)'(s_valido[k]);
    end
  end
  assign fa_ocupacao_out = ocupacao;
  assign fa_vazio_out    = (ocupacao == '0);
  assign fa_cheio_out    = (ocupacao == (IDX_WIDTH+1)'(NUM_NA));

  // CAM match (addresses are unique in the set, so at most one hit)
  // and lowest-index free slot (descending loop lets the lowest win)
  logic                 casa_algum, livre_algum;
  logic [IDX_WIDTH-1:0] casa_idx, livre_idx;
  always_comb begin
    casa_algum  = 1'b0;
    casa_idx    = '0;
    livre_algum = 1'b0;
    livre_idx   = '0;
    for (int k = 0; k < NUM_NA; k++) begin
      if (s_casa[k]) begin
        casa_algum = 1'b1;
        casa_idx   = IDX_WIDTH'(k);
      end
    end
    for (int k = NUM_NA - 1; k >= 0; k--) begin
      if (!s_valido[k]) begin
        livre_algum = 1'b1;
        livre_idx   = IDX_WIDTH'(k);
      end
    end
  end

  logic relaxa, aloca, descarte, overflow_evt;
  assign relaxa       = casa_algum && (crit_cmd < s_criterio[casa_idx]);
  assign aloca        = !casa_algum && livre_algum;
  assign descarte     = cmd_fire && !relaxa && !aloca;
  assign overflow_evt = cmd_fire && !casa_algum && !livre_algum;

  // sequential scan: one slot per BUSCA cycle, strict < keeps the lowest index on ties
  logic [IDX_WIDTH-1:0]      scan_idx;
  logic                      melhor_achou;
  logic [IDX_WIDTH-1:0]      melhor_idx;
  logic [CRITERIO_WIDTH-1:0] melhor_crit;
  logic                      examinar, prox_achou, ultimo;
  logic [IDX_WIDTH-1:0]      prox_idx;
  logic [CRITERIO_WIDTH-1:0] prox_crit;

  assign examinar   = s_valido[scan_idx] && (!melhor_achou || (s_criterio[scan_idx] < melhor_crit));
  assign prox_achou = melhor_achou || s_valido[scan_idx];
  assign prox_idx   = examinar ? scan_idx : melhor_idx;
  assign prox_crit  = examinar ? s_criterio[scan_idx] : melhor_crit;
  assign ultimo     = (estado == BUSCA) && (scan_idx == IDX_WIDTH'(NUM_NA - 1)) && !limpar_in;

  always_comb begin
    for (int k = 0; k < NUM_NA; k++) begin
      s_escrever[k]  = cmd_fire && aloca && (livre_idx == IDX_WIDTH'(k));
      s_relaxar[k]   = cmd_fire && relaxa && (casa_idx == IDX_WIDTH'(k));
      s_invalidar[k] = ultimo && (prox_idx == IDX_WIDTH'(k));
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox   = estado;
    cmd_ready_out = 1'b0;
    pop_ready_out = 1'b0;
    pop_valid_out = 1'b0;
    case (estado)
      OCIOSO: begin
        cmd_ready_out = 1'b1;
        pop_ready_out = !cmd_valid_in;
        if (pop_fire) estado_prox = fa_vazio_out ? ENTREGA : BUSCA;
      end
      BUSCA: begin
        if (scan_idx == IDX_WIDTH'(NUM_NA - 1)) estado_prox = ENTREGA;
      end
      ENTREGA: begin
        pop_valid_out = 1'b1;
        estado_prox   = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
    if (limpar_in) estado_prox = OCIOSO;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx           <= '0;
      melhor_achou       <= 1'b0;
      melhor_idx         <= '0;
      melhor_crit        <= '0;
      cmd_descartado_out <= 1'b0;
      fa_overflow_out    <= 1'b0;
      pop_nulo_out       <= 1'b0;
      pop_endereco_out   <= '0;
      pop_distancia_out  <= '0;
      pop_anterior_out   <= '0;
    end else if (limpar_in) begin
      scan_idx           <= '0;
      melhor_achou       <= 1'b0;
      cmd_descartado_out <= 1'b0;
      fa_overflow_out    <= 1'b0;
    end else begin
      cmd_descartado_out <= descarte;
      if (overflow_evt) fa_overflow_out <= 1'b1;
      if (pop_fire) begin
        scan_idx     <= '0;
        melhor_achou <= 1'b0;
        if (fa_vazio_out) begin
          pop_nulo_out      <= 1'b1;
          pop_endereco_out  <= '0;
          pop_distancia_out <= '0;
          pop_anterior_out  <= '0;
        end
      end
      if (estado == BUSCA) begin
        scan_idx     <= scan_idx + 1'b1;
        melhor_achou <= prox_achou;
        melhor_idx   <= prox_idx;
        melhor_crit  <= prox_crit;
      end
      // result is latched on the edge into ENTREGA, same edge that frees the slot
      if (ultimo) begin
        pop_nulo_out      <= 1'b0;
        pop_endereco_out  <= s_endereco[prox_idx];
        pop_distancia_out <= s_distancia[prox_idx];
        pop_anterior_out  <= s_anterior[prox_idx];
      end
    end
  end

endmodule

// File: tb/tb_fila_ativos_min.sv
// tb/tb_fila_ativos_min.sv - directed self-checking bench for fila_ativos_min
module tb_fila_ativos_min;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       limpar_in = 1'b0;
  logic       cmd_valid_in = 1'b0;
  logic       cmd_ready_out;
  logic [4:0] cmd_endereco_in = '0;
  logic [4:0] cmd_distancia_in = '0;
  logic [4:0] cmd_heuristica_in = '0;
  logic [4:0] cmd_anterior_in = '0;
  logic       cmd_descartado_out;
  logic       pop_req_in = 1'b0;
  logic       pop_ready_out;
  logic       pop_valid_out;
  logic       pop_nulo_out;
  logic [4:0] pop_endereco_out;
  logic [4:0] pop_distancia_out;
  logic [4:0] pop_anterior_out;
  logic [2:0] fa_ocupacao_out;
  logic       fa_vazio_out;
  logic       fa_cheio_out;
  logic       fa_overflow_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fila_ativos_min #(
    .NUM_NA          (4),
    .ADDR_WIDTH      (5),
    .DISTANCIA_WIDTH (5),
    .HEUR_WIDTH      (5)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .limpar_in          (limpar_in),
    .cmd_valid_in       (cmd_valid_in),
    .cmd_ready_out      (cmd_ready_out),
    .cmd_endereco_in    (cmd_endereco_in),
    .cmd_distancia_in   (cmd_distancia_in),
    .cmd_heuristica_in  (cmd_heuristica_in),
    .cmd_anterior_in    (cmd_anterior_in),
    .cmd_descartado_out (cmd_descartado_out),
    .pop_req_in         (pop_req_in),
    .pop_ready_out      (pop_ready_out),
    .pop_valid_out      (pop_valid_out),
    .pop_nulo_out       (pop_nulo_out),
    .pop_endereco_out   (pop_endereco_out),
    .pop_distancia_out  (pop_distancia_out),
    .pop_anterior_out   (pop_anterior_out),
    .fa_ocupacao_out    (fa_ocupacao_out),
    .fa_vazio_out       (fa_vazio_out),
    .fa_cheio_out       (fa_cheio_out),
    .fa_overflow_out    (fa_overflow_out)
  );

  // one accepted command; returns at the negedge after the acceptance edge
  task automatic do_insert(input logic [4:0] e, input logic [4:0] d, input logic [4:0] h, input logic [4:0] a);
    @(negedge clk);
    cmd_valid_in      = 1'b1;
    cmd_endereco_in   = e;
    cmd_distancia_in  = d;
    cmd_heuristica_in = h;
    cmd_anterior_in   = a;
    @(negedge clk);
    cmd_valid_in = 1'b0;
  endtask

  // one accepted pop; lat counts cycles from acceptance to the strobe (bounded)
  task automatic do_pop(output int lat, output logic [4:0] e, output logic [4:0] d,
                        output logic [4:0] a, output logic nulo);
    @(negedge clk);
    pop_req_in = 1'b1;
    @(negedge clk);
    pop_req_in = 1'b0;
    lat = 1;
    while (!pop_valid_out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e    = pop_endereco_out;
    d    = pop_distancia_out;
    a    = pop_anterior_out;
    nulo = pop_nulo_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready_out !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_out); end
    checks++; if (pop_ready_out !== 1'b1) begin errors++; $display("FAIL reset_pop_ready got %b want 1", pop_ready_out); end
    checks++; if (pop_valid_out !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %b want 0", pop_valid_out); end
    checks++; if (fa_vazio_out !== 1'b1) begin errors++; $display("FAIL reset_vazio got %b want 1", fa_vazio_out); end
    checks++; if (fa_ocupacao_out !== 3'd0) begin errors++; $display("FAIL reset_ocupacao got %0d want 0", fa_ocupacao_out); end
    checks++; if (fa_cheio_out !== 1'b0) begin errors++; $display("FAIL reset_cheio got %b want 0", fa_cheio_out); end
    checks++; if (fa_overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", fa_overflow_out); end
    checks++; if (cmd_descartado_out !== 1'b0) begin errors++; $display("FAIL reset_descartado got %b want 0", cmd_descartado_out); end
    checks++; if (pop_endereco_out !== 5'd0) begin errors++; $display("FAIL reset_pop_end got %0d want 0", pop_endereco_out); end
  endtask

  task automatic test_insert_pop();
    int lat; logic [4:0] e, d, a; logic n;
    do_insert(5'd3, 5'd4, 5'd2, 5'd1);
    checks++; if (fa_ocupacao_out !== 3'd1) begin errors++; $display("FAIL ins_ocupacao got %0d want 1", fa_ocupacao_out); end
    checks++; if (fa_vazio_out !== 1'b0) begin errors++; $display("FAIL ins_vazio got %b want 0", fa_vazio_out); end
    checks++; if (cmd_descartado_out !== 1'b0) begin errors++; $display("FAIL ins_descartado got %b want 0", cmd_descartado_out); end
    do_pop(lat, e, d, a, n);
    checks++; if (lat !== 5) begin errors++; $display("FAIL pop_latency got %0d want 5", lat); end
    checks++; if (e !== 5'd3) begin errors++; $display("FAIL pop_end got %0d want 3", e); end
    checks++; if (d !== 5'd4) begin errors++; $display("FAIL pop_dist got %0d want 4", d); end
    checks++; if (a !== 5'd1) begin errors++; $display("FAIL pop_ant got %0d want 1", a); end
    checks++; if (n !== 1'b0) begin errors++; $display("FAIL pop_nulo got %b want 0", n); end
    checks++; if (fa_vazio_out !== 1'b1) begin errors++; $display("FAIL pop_vazio got %b want 1", fa_vazio_out); end
    @(negedge clk);
    checks++; if (pop_valid_out !== 1'b0) begin errors++; $display("FAIL pop_strobe_len got %b want 0", pop_valid_out); end
    checks++; if (pop_endereco_out !== 5'd3) begin errors++; $display("FAIL pop_hold got %0d want 3", pop_endereco_out); end
  endtask

  task automatic test_relax();
    int lat; logic [4:0] e, d, a; logic n;
    do_insert(5'd7, 5'd10, 5'd1, 5'd0);
    do_insert(5'd7, 5'd6, 5'd1, 5'd2);
    checks++; if (cmd_descartado_out !== 1'b0) begin errors++; $display("FAIL relax_descartado got %b want 0", cmd_descartado_out); end
    checks++; if (fa_ocupacao_out !== 3'd1) begin errors++; $display("FAIL relax_ocupacao got %0d want 1", fa_ocupacao_out); end
    do_insert(5'd7, 5'd6, 5'd1, 5'd5);
    checks++; if (cmd_descartado_out !== 1'b1) begin errors++; $display("FAIL equal_descartado got %b want 1", cmd_descartado_out); end
    @(negedge clk);
    checks++; if (cmd_descartado_out !== 1'b0) begin errors++; $display("FAIL descartado_pulse got %b want 0", cmd_descartado_out); end
    do_pop(lat, e, d, a, n);
    checks++; if (e !== 5'd7) begin errors++; $display("FAIL relax_pop_end got %0d want 7", e); end
    checks++; if (d !== 5'd6) begin errors++; $display("FAIL relax_pop_dist got %0d want 6", d); end
    checks++; if (a !== 5'd2) begin errors++; $display("FAIL relax_pop_ant got %0d want 2", a); end
  endtask

  task automatic test_overflow();
    int lat; logic [4:0] e, d, a; logic n;
    do_insert(5'd1, 5'd8, 5'd1, 5'd11);  // crit 9, slot 0
    do_insert(5'd2, 5'd3, 5'd2, 5'd12);  // crit 5, slot 1
    do_insert(5'd3, 5'd5, 5'd0, 5'd13);  // crit 5, slot 2
    do_insert(5'd4, 5'd4, 5'd4, 5'd14);  // crit 8, slot 3
    checks++; if (fa_cheio_out !== 1'b1) begin errors++; $display("FAIL full_cheio got %b want 1", fa_cheio_out); end
    checks++; if (fa_ocupacao_out !== 3'd4) begin errors++; $display("FAIL full_ocupacao got %0d want 4", fa_ocupacao_out); end
    checks++; if (fa_overflow_out !== 1'b0) begin errors++; $display("FAIL full_overflow_early got %b want 0", fa_overflow_out); end
    do_insert(5'd5, 5'd1, 5'd0, 5'd15);
    checks++; if (cmd_descartado_out !== 1'b1) begin errors++; $display("FAIL ovf_descartado got %b want 1", cmd_descartado_out); end
    checks++; if (fa_overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", fa_overflow_out); end
    checks++; if (fa_cheio_out !== 1'b1) begin errors++; $display("FAIL ovf_cheio got %b want 1", fa_cheio_out); end
    do_pop(lat, e, d, a, n);
    checks++; if (e !== 5'd2) begin errors++; $display("FAIL tie_pop_end got %0d want 2", e); end
    checks++; if (d !== 5'd3) begin errors++; $display("FAIL tie_pop_dist got %0d want 3", d); end
    checks++; if (a !== 5'd12) begin errors++; $display("FAIL tie_pop_ant got %0d want 12", a); end
    checks++; if (fa_ocupacao_out !== 3'd3) begin errors++; $display("FAIL tie_ocupacao got %0d want 3", fa_ocupacao_out); end
    checks++; if (fa_overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", fa_overflow_out); end
  endtask

  task automatic test_empty_pop();
    int lat; logic [4:0] e, d, a; logic n;
    @(negedge clk); limpar_in = 1'b1;
    @(negedge clk); limpar_in = 1'b0;
    checks++; if (fa_ocupacao_out !== 3'd0) begin errors++; $display("FAIL limpar_ocupacao got %0d want 0", fa_ocupacao_out); end
    checks++; if (fa_overflow_out !== 1'b0) begin errors++; $display("FAIL limpar_overflow got %b want 0", fa_overflow_out); end
    do_pop(lat, e, d, a, n);
    checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency got %0d want 1", lat); end
    checks++; if (n !== 1'b1) begin errors++; $display("FAIL empty_nulo got %b want 1", n); end
    checks++; if (e !== 5'd0 || d !== 5'd0 || a !== 5'd0) begin errors++; $display("FAIL empty_data got %0d/%0d/%0d want 0/0/0", e, d, a); end
  endtask

  task automatic test_priority();
    int lat;
    do_insert(5'd9, 5'd10, 5'd0, 5'd1);  // crit 10
    @(negedge clk);
    cmd_valid_in      = 1'b1;
    cmd_endereco_in   = 5'd10;
    cmd_distancia_in  = 5'd2;
    cmd_heuristica_in = 5'd1;
    cmd_anterior_in   = 5'd3;
    pop_req_in        = 1'b1;
    #1;
    checks++; if (pop_ready_out !== 1'b0) begin errors++; $display("FAIL prio_pop_ready got %b want 0", pop_ready_out); end
    checks++; if (cmd_ready_out !== 1'b1) begin errors++; $display("FAIL prio_cmd_ready got %b want 1", cmd_ready_out); end
    @(negedge clk);
    cmd_valid_in = 1'b0;
    #1;
    checks++; if (pop_ready_out !== 1'b1) begin errors++; $display("FAIL prio_pop_ready2 got %b want 1", pop_ready_out); end
    checks++; if (fa_ocupacao_out !== 3'd2) begin errors++; $display("FAIL prio_ocupacao got %0d want 2", fa_ocupacao_out); end
    @(negedge clk);
    pop_req_in = 1'b0;
    checks++; if (cmd_ready_out !== 1'b0 || pop_ready_out !== 1'b0) begin errors++; $display("FAIL busca_readys got %b%b want 00", cmd_ready_out, pop_ready_out); end
    lat = 1;
    while (!pop_valid_out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL prio_latency got %0d want 5", lat); end
    checks++; if (pop_endereco_out !== 5'd10) begin errors++; $display("FAIL prio_pop_end got %0d want 10", pop_endereco_out); end
    checks++; if (pop_distancia_out !== 5'd2) begin errors++; $display("FAIL prio_pop_dist got %0d want 2", pop_distancia_out); end
    checks++; if (fa_ocupacao_out !== 3'd1) begin errors++; $display("FAIL prio_ocupacao_after got %0d want 1", fa_ocupacao_out); end
  endtask

  task automatic test_abort(input logic use_reset);
    logic visto;
    if (!use_reset) begin
      do_insert(5'd11, 5'd1, 5'd0, 5'd0);
      do_insert(5'd12, 5'd2, 5'd0, 5'd0);
      do_insert(5'd13, 5'd3, 5'd0, 5'd0);
      do_insert(5'd14, 5'd4, 5'd0, 5'd0);
      checks++; if (fa_overflow_out !== 1'b1) begin errors++; $display("FAIL abort_overflow_set got %b want 1", fa_overflow_out); end
    end else begin
      do_insert(5'd21, 5'd5, 5'd0, 5'd0);
      do_insert(5'd22, 5'd6, 5'd0, 5'd0);
    end
    visto = 1'b0;
    @(negedge clk); pop_req_in = 1'b1;
    @(negedge clk); pop_req_in = 1'b0;
    visto = visto | pop_valid_out;
    @(negedge clk);
    visto = visto | pop_valid_out;
    if (use_reset) rst_n = 1'b0;
    else           limpar_in = 1'b1;
    @(negedge clk);
    visto = visto | pop_valid_out;
    rst_n = 1'b1;
    limpar_in = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready_out !== 1'b1 || pop_ready_out !== 1'b1) begin errors++; $display("FAIL abort_readys reset=%b got %b%b want 11", use_reset, cmd_ready_out, pop_ready_out); end
    checks++; if (fa_ocupacao_out !== 3'd0) begin errors++; $display("FAIL abort_ocupacao reset=%b got %0d want 0", use_reset, fa_ocupacao_out); end
    checks++; if (fa_overflow_out !== 1'b0) begin errors++; $display("FAIL abort_overflow reset=%b got %b want 0", use_reset, fa_overflow_out); end
    for (int k = 0; k < 8; k++) begin
      visto = visto | pop_valid_out;
      @(negedge clk);
    end
    checks++; if (visto !== 1'b0) begin errors++; $display("FAIL abort_strobe reset=%b got %b want 0", use_reset, visto); end
  endtask

  initial begin
    test_reset();
    test_insert_pop();
    test_relax();
    test_overflow();
    test_empty_pop();
    test_priority();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
